uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 25_000_000, meaning the clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 115_200, meaning the line bit rate.
REQ-003 The module SHALL have parameter DATA_BITS, default 8, meaning the data bits per frame, legal range 5..8.
REQ-004 The module SHALL have parameter PARITY, default 0, meaning 0=none, 1=even, 2=odd.
REQ-005 The module SHALL have parameter STOP_BITS, default 1, meaning the stop bits per frame, legal values 1 or 2.
REQ-006 The module SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The module SHALL have port i_valid, input, 1 bit: a byte is offered on i_data.
REQ-009 The module SHALL have port i_data, input, 8 bits: the byte to send; bits [7:DATA_BITS] are ignored.
REQ-010 The module SHALL have port o_ready, output, 1 bit: the holding register is empty and can accept a byte.
REQ-011 The module SHALL have port o_tx, output, 1 bit: the registered serial line output, which idles high.
REQ-012 The module SHALL have port o_busy, output, 1 bit: a frame is in progress or the holding register is full.

Function
REQ-013 The module SHALL derive CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division); elaboration SHALL fail if CLKS_PER_BIT<2, DATA_BITS is outside 5..8, PARITY>2, or STOP_BITS is not 1 or 2.
REQ-014 A transfer SHALL occur on a rising edge where i_valid=1 and o_ready=1; i_data SHALL be captured into the 1-deep holding register.
REQ-015 i_valid while o_ready=0 SHALL be ignored; no data is captured and no state changes.
REQ-016 o_ready SHALL equal (holding register empty) AND NOT i_reset (combinational).
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; unreachable encodings SHALL return to IDLE with o_tx=1.
REQ-018 Transitions SHALL be:
- IDLE→START when the holding register is full; the holding contents load into the shift register and the holding register empties in the same edge.
- START→DATA after 1 bit time.
- DATA→PARITY, or →STOP if PARITY=0, after DATA_BITS bit times.
- PARITY→STOP after 1 bit time.
- STOP→START (holding full) or →IDLE (holding empty) after STOP_BITS bit times.
REQ-019 Each bit time SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that clears on every bit boundary and on entry to START.
REQ-020 Line levels SHALL be:
- START: 0.
- DATA: bits LSB first.
- PARITY: XOR of the DATA_BITS data bits (even), inverted (odd).
- STOP and IDLE: 1.
REQ-021 Latency: for a transfer at edge E0 while IDLE, o_tx SHALL first read 0 after edge E2.
REQ-022 Frame length SHALL be CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
REQ-023 Back-to-back: if the holding register is full at the final stop-bit cycle, the next start bit SHALL begin on the immediately following cycle with zero idle cycles.
REQ-024 A transfer accepted during the same edge the FSM drains the holding register SHALL NOT occur, because o_ready=0 while the register is full; the next byte is accepted the cycle after draining.
REQ-025 The module SHALL drive o_busy = (state!=IDLE) OR (holding register full).
REQ-026 Parity SHALL be computed from the captured byte, not from the live i_data.

Reset
REQ-027 While i_reset=1 on an edge, the module SHALL set state=IDLE, o_tx=1, baud counter=0, bit index=0, shift register=0, and holding register empty; o_busy=0 after that edge.
REQ-028 Reset mid-frame SHALL abort the frame; o_tx=1 after the reset edge; any held byte SHALL be discarded, and no frame SHALL resume after reset deasserts.
REQ-029 o_ready SHALL be 0 during reset and 1 on the first cycle after reset deasserts.

Verification
All scenarios use CLK_FREQ=1_000_000 and BAUD_RATE=250_000, giving CLKS_PER_BIT=4.
REQ-030 8N1, send 0xA5 -> o_tx = 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles, 40 cycles total; o_busy high throughout, low afterwards.
REQ-031 7E1 (DATA_BITS=7, PARITY=1), send 0xD3 -> data 1,1,0,0,1,0,1 and parity 0 (bit 7 ignored); frame length 40 cycles.
REQ-032 8O2 (PARITY=2, STOP_BITS=2), send 0x00 -> eight 0 data bits, parity 1, two stop bits; frame length 48 cycles.
REQ-033 Back-to-back: i_valid held with 0x55 then 0x0F -> second byte accepted during frame 1; o_ready=0 until frame 2 starts; frame 2 start bit immediately follows the frame-1 stop bit with no idle cycle.
REQ-034 Overflow: a third byte is offered for one cycle while o_ready=0 -> it is never transmitted; exactly two frames appear.
REQ-035 Reset asserted during data bit 3 of 0x3C with 0x81 held -> o_tx=1 and o_busy=0 after the reset edge; no further frames; o_ready=1 one cycle after release.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a 1-deep holding register and registered line output.
// Frame format (data bits, parity, stop bits) and bit time are fixed at elaboration.
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | line high, waiting for the holding register to fill
// S_START  | start bit (line low) for one bit time
// S_DATA   | DATA_BITS data bits, LSB first
// S_PARITY | parity bit (only when PARITY != 0)
// S_STOP   | STOP_BITS stop bits, then next frame or idle
module uart_tx_cfg #(
   parameter int CLK_FREQ  = 25_000_000,
   parameter int BAUD_RATE = 115_200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_valid,
   input  logic [7:0] i_data,
   output logic       o_ready,
   output logic       o_tx,
   output logic       o_busy
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
       (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
      $error("uart_tx_cfg: illegal parameter combination");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic   [CNT_W-1:0] cnt;
   logic   [2:0]       bit_idx;
   logic   [7:0]       shift;
   logic               par_bit;
   logic   [7:0]       hold_data;
   logic               hold_full;
   logic               bit_done;
   logic               load;
   logic               accept;
   logic               par_calc;
   logic               tx_nxt;

   assign bit_done = (cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign load     = (state_nxt == S_START) && (state == S_IDLE || state == S_STOP);
   assign o_ready  = !hold_full && !i_reset;
   assign accept   = i_valid && o_ready;
   assign o_busy   = (state != S_IDLE) || hold_full;
   // Parity comes from the held byte so later changes on i_data cannot affect it.
   assign par_calc = (^(hold_data & DATA_MASK)) ^ (PARITY == 2);

   always_comb begin
      state_nxt = state;
      tx_nxt    = 1'b1;
      case (state)
         S_IDLE: begin
            if (hold_full) state_nxt = S_START;
         end
         S_START: begin
            tx_nxt = 1'b0;
            if (bit_done) state_nxt = S_DATA;
         end
         S_DATA: begin
            tx_nxt = shift[0];
            if (bit_done && bit_idx == 3'(DATA_BITS - 1))
               state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            tx_nxt = par_bit;
            if (bit_done) state_nxt = S_STOP;
         end
         S_STOP: begin
            if (bit_done && bit_idx == 3'(STOP_BITS - 1))
               state_nxt = hold_full ? S_START : S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= S_IDLE;
         o_tx      <= 1'b1;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         par_bit   <= 1'b0;
         hold_data <= '0;
         hold_full <= 1'b0;
      end else begin
         state <= state_nxt;
         o_tx  <= tx_nxt;

         if (bit_done || state == S_IDLE) cnt <= '0;
         else                             cnt <= cnt + 1'b1;

         if (state_nxt != state) bit_idx <= '0;
         else if (bit_done)      bit_idx <= bit_idx + 3'd1;

         // load needs a full holding register, accept needs an empty one
         if (load) begin
            shift     <= hold_data;
            par_bit   <= par_calc;
            hold_full <= 1'b0;
         end else begin
            if (state == S_DATA && bit_done) shift <= shift >> 1;
            if (accept) begin
               hold_data <= i_data;
               hold_full <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8N1, 7E1 and 8O2 frames, back-to-back, overflow and mid-frame reset.
// CLKS_PER_BIT is 4 for every instance.
module tb_uart_tx_cfg;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_a, valid_b, valid_c;
   logic [7:0] data_a, data_b, data_c;
   logic       ready_a, ready_b, ready_c;
   logic       tx_a, tx_b, tx_c;
   logic       busy_a, busy_b, busy_c;
   logic       tx_s, busy_s;
   int         sel;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      case (sel)
         1:       begin tx_s = tx_b; busy_s = busy_b; end
         2:       begin tx_s = tx_c; busy_s = busy_c; end
         default: begin tx_s = tx_a; busy_s = busy_a; end
      endcase
   end

   uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000)) u_8n1 (
      .i_clk(clk), .i_reset(rst), .i_valid(valid_a), .i_data(data_a),
      .o_ready(ready_a), .o_tx(tx_a), .o_busy(busy_a));

   uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000), .DATA_BITS(7), .PARITY(1)) u_7e1 (
      .i_clk(clk), .i_reset(rst), .i_valid(valid_b), .i_data(data_b),
      .o_ready(ready_b), .o_tx(tx_b), .o_busy(busy_b));

   uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(250_000), .PARITY(2), .STOP_BITS(2)) u_8o2 (
      .i_clk(clk), .i_reset(rst), .i_valid(valid_c), .i_data(data_c),
      .o_ready(ready_c), .o_tx(tx_c), .o_busy(busy_c));

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) for the start bit on the selected line, then checks every cycle of the frame.
   task automatic check_frame(input string tag, input logic [7:0] b, input int nbits,
                              input int par_en, input logic par_val, input int stops,
                              input int max_wait, output int waited);
      logic bits [0:11];
      int   len;
      waited = 0;
      while (tx_s !== 1'b0 && waited < max_wait) begin
         @(negedge clk);
         waited++;
      end
      chk_val({tag, "_start"}, tx_s, 0);
      if (tx_s !== 1'b0) return;
      len = 0;
      bits[len] = 1'b0; len++;
      for (int i = 0; i < nbits; i++) begin bits[len] = b[i]; len++; end
      if (par_en != 0) begin bits[len] = par_val; len++; end
      for (int i = 0; i < stops; i++) begin bits[len] = 1'b1; len++; end
      for (int k = 0; k < len; k++) begin
         for (int c = 0; c < 4; c++) begin
            if (!(k == 0 && c == 0)) @(negedge clk);
            chk_val($sformatf("%s_bit%0d_c%0d", tag, k, c), tx_s, bits[k]);
            if (c == 1) chk_val($sformatf("%s_busy%0d", tag, k), busy_s, 1);
         end
      end
   endtask

   task automatic run_single(input int s, input logic [7:0] b, input int nbits, input int par_en,
                             input logic par_val, input int stops, input string tag);
      int w;
      sel = s;
      @(negedge clk);
      case (s)
         1:       begin valid_b = 1'b1; data_b = b; end
         2:       begin valid_c = 1'b1; data_c = b; end
         default: begin valid_a = 1'b1; data_a = b; end
      endcase
      @(posedge clk);
      @(negedge clk);
      valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
      check_frame(tag, b, nbits, par_en, par_val, stops, 20, w);
      chk_val({tag, "_latency"}, w, 2);
      @(negedge clk);
      chk_val({tag, "_busy_after"}, busy_s, 0);
      chk_val({tag, "_tx_after"}, tx_s, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int zeros;
      int busy_seen;
      sel = 0;
      rst = 1'b1;
      valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
      data_a = 8'h00; data_b = 8'h00; data_c = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_val("rst_tx", tx_a, 1);
      chk_val("rst_busy", busy_a, 0);
      chk_val("rst_ready_a", ready_a, 0);
      chk_val("rst_ready_b", ready_b, 0);
      chk_val("rst_ready_c", ready_c, 0);
      rst = 1'b0;
      @(negedge clk);
      chk_val("ready_after_rst_a", ready_a, 1);
      chk_val("ready_after_rst_b", ready_b, 1);
      chk_val("ready_after_rst_c", ready_c, 1);
      chk_val("idle_tx_c", tx_c, 1);

      // 0xA5 -> 1,0,1,0,0,1,0,1 ; 0xD3 low 7 bits -> 1,1,0,0,1,0,1 (four ones, even parity 0)
      run_single(0, 8'hA5, 8, 0, 1'b0, 1, "8n1_a5");
      run_single(1, 8'hD3, 7, 1, 1'b0, 1, "7e1_d3");
      run_single(2, 8'h00, 8, 1, 1'b1, 2, "8o2_00");
      run_single(1, 8'h01, 7, 1, 1'b1, 1, "7e1_01");

      // Back-to-back 0x55, 0x0F with an ignored 0xEE offered while full
      sel = 0;
      repeat (3) @(negedge clk);
      fork
         begin
            valid_a = 1'b1; data_a = 8'h55;
            @(posedge clk);
            @(negedge clk);
            data_a = 8'h0F;
            chk_val("b2b_ready_full0", ready_a, 0);
            @(negedge clk);
            chk_val("b2b_ready_drained", ready_a, 1);
            @(negedge clk);
            valid_a = 1'b0;
            chk_val("b2b_ready_full1", ready_a, 0);
            repeat (5) @(negedge clk);
            valid_a = 1'b1; data_a = 8'hEE;
            chk_val("ovf_ready", ready_a, 0);
            @(negedge clk);
            valid_a = 1'b0;
            repeat (32) @(negedge clk);
            chk_val("b2b_ready_before_f2", ready_a, 0);
            @(negedge clk);
            chk_val("b2b_ready_at_f2", ready_a, 1);
         end
         begin
            @(posedge clk);
            @(negedge clk);
            check_frame("b2b_f1", 8'h55, 8, 0, 1'b0, 1, 20, w);
            chk_val("b2b_f1_latency", w, 2);
            @(negedge clk);
            check_frame("b2b_f2", 8'h0F, 8, 0, 1'b0, 1, 0, w);
         end
      join
      zeros = 0;
      busy_seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx_a !== 1'b1) zeros++;
      end
      if (busy_a !== 1'b0) busy_seen = 1;
      chk_val("ovf_no_third_frame", zeros, 0);
      chk_val("ovf_busy_idle", busy_seen, 0);

      // Reset during data bit 3 of 0x3C while 0x81 is held
      @(negedge clk);
      valid_a = 1'b1; data_a = 8'h3C;
      @(posedge clk);
      @(negedge clk);
      data_a = 8'h81;
      @(negedge clk);
      @(negedge clk);
      valid_a = 1'b0;
      chk_val("rstmid_held", ready_a, 0);
      repeat (9) @(negedge clk);
      chk_val("rstmid_bit1", tx_a, 0);
      repeat (8) @(negedge clk);
      chk_val("rstmid_bit3", tx_a, 1);
      rst = 1'b1;
      chk_val("rstmid_ready_in_rst", ready_a, 0);
      @(negedge clk);
      chk_val("rstmid_tx", tx_a, 1);
      chk_val("rstmid_busy", busy_a, 0);
      rst = 1'b0;
      @(negedge clk);
      chk_val("rstmid_ready_release", ready_a, 1);
      zeros = 0;
      busy_seen = 0;
      repeat (80) begin
         @(negedge clk);
         if (tx_a !== 1'b1) zeros++;
         if (busy_a !== 1'b0) busy_seen++;
      end
      chk_val("rstmid_no_resume", zeros, 0);
      chk_val("rstmid_busy_low", busy_seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
